// File: rtl/mem_write_tap.sv
// Snoops CPU stores that fall inside an address window and queues them in a small
// first-word-fall-through FIFO for a downstream consumer; never back-pressures the CPU.
module mem_write_tap #(
    parameter int           N        = 32,
    parameter int           DEPTH    = 8,
    parameter logic [N-1:0] BASE_ADR = 32'h0000_0080,
    parameter logic [N-1:0] WIN_MASK = 32'hFFFF_FF80
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 memwrite,
    input  logic [N-1:0]               dataadr,
    input  logic [N-1:0]               writedata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_kind,
    output logic [N-1:0]               out_adr,
    output logic [N-1:0]               out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 drops,
    output logic                       overflow,
    input  logic                       clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [1:0]   kind;
        logic [N-1:0] adr;
        logic [N-1:0] data;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          head;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          hit, full, pop, push, drop;

    assign hit  = (memwrite != 2'b00) && ((dataadr & WIN_MASK) == BASE_ADR);
    assign full = (level == LW'(DEPTH));
    assign pop  = out_valid && out_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign push = hit && (!full || pop);
    assign drop = hit && full && !pop;

    assign out_valid = (level != '0);
    assign head      = mem[rd_ptr];
    assign out_kind  = out_valid ? head.kind : '0;
    assign out_adr   = out_valid ? head.adr  : '0;
    assign out_data  = out_valid ? head.data : '0;

    // Storage carries no reset; empty-state outputs are masked by out_valid instead.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{kind: memwrite, adr: dataadr, data: writedata};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            drops    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            // Clear is applied first so a coincident drop still gets counted.
            if (drop) begin
                overflow <= 1'b1;
                if (clr_ovf)
                    drops <= 8'h01;
                else if (drops != 8'hFF)
                    drops <= drops + 8'h01;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
                drops    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_write_tap.sv
// Randomized self-checking bench for mem_write_tap against a queue-based reference model.
module tb_mem_write_tap;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_0080;
    localparam logic [31:0] MASK  = 32'hFFFF_FF80;

    logic        clk = 0, reset = 1;
    logic [1:0]  memwrite = 0;
    logic [31:0] dataadr = 0, writedata = 0;
    logic        out_ready = 0, clr_ovf = 0;
    logic        out_valid, overflow;
    logic [1:0]  out_kind;
    logic [31:0] out_adr, out_data;
    logic [3:0]  level;
    logic [7:0]  drops;

    int errs = 0, checks = 0;

    typedef struct {
        logic [1:0]  k;
        logic [31:0] a;
        logic [31:0] d;
    } rec_t;
    rec_t q[$];
    int   m_drops = 0;
    bit   m_ovf = 0;

    mem_write_tap #(.N(32), .DEPTH(DEPTH), .BASE_ADR(BASE), .WIN_MASK(MASK)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_adr(out_adr), .out_data(out_data), .level(level),
        .drops(drops), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model on the edge, return 1 time unit later.
    task automatic step(input logic [1:0] mw, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy, input logic clr);
        bit pop, hit;
        memwrite = mw; dataadr = a; writedata = d; out_ready = rdy; clr_ovf = clr;
        @(posedge clk);
        pop = (q.size() != 0) && rdy;
        hit = (mw != 2'b00) && ((a & MASK) == BASE);
        if (pop) void'(q.pop_front());
        if (clr) begin m_drops = 0; m_ovf = 0; end
        if (hit) begin
            if (q.size() < DEPTH) q.push_back('{mw, a, d});
            else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
        #1;
        memwrite = 0; out_ready = 0; clr_ovf = 0;
    endtask

    function automatic logic [31:0] win_adr();
        return BASE | 32'($urandom_range(0, 127));
    endfunction

    task automatic test_reset;
        reset = 1;
        #12;
        checks++; if (level !== 4'd0) begin errs++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (out_valid !== 1'b0 || out_adr !== 32'd0 || out_data !== 32'd0 || out_kind !== 2'd0) begin
            errs++; $display("FAIL reset_outs got v=%b a=%h d=%h exp 0", out_valid, out_adr, out_data); end
        checks++; if (drops !== 8'd0 || overflow !== 1'b0) begin
            errs++; $display("FAIL reset_drops got d=%0d o=%b exp 0/0", drops, overflow); end
        @(negedge clk) reset = 0;
    endtask

    task automatic test_first_store;
        step(2'b01, 32'h84, 32'hDEADBEEF, 0, 0);
        checks++; if (out_valid !== 1'b1 || out_kind !== 2'b01 || out_adr !== 32'h84 ||
                      out_data !== 32'hDEADBEEF || level !== 4'd1) begin
            errs++; $display("FAIL first_store got v=%b k=%b a=%h d=%h l=%0d exp 1/01/84/deadbeef/1",
                             out_valid, out_kind, out_adr, out_data, level); end
        step(0, 0, 0, 1, 0);
        checks++; if (out_valid !== 1'b0 || out_data !== 32'd0 || level !== 4'd0) begin
            errs++; $display("FAIL first_drain got v=%b d=%h l=%0d exp 0/0/0", out_valid, out_data, level); end
    endtask

    task automatic test_filter;
        step(2'b01, 32'h40, 32'h1111, 0, 0);
        step(2'b00, 32'h80, 32'h2222, 0, 0);
        step(2'b11, 32'h100, 32'h3333, 0, 0);
        checks++; if (out_valid !== 1'b0 || level !== 4'd0 || out_adr !== 32'd0) begin
            errs++; $display("FAIL filter got v=%b l=%0d a=%h exp 0/0/0", out_valid, level, out_adr); end
    endtask

    task automatic test_overflow_drain;
        for (int i = 1; i <= 9; i++) step(2'b10, 32'h80 + 32'(4 * i), 32'(i), 0, 0);
        checks++; if (level !== 4'd8 || overflow !== 1'b1 || drops !== 8'd1) begin
            errs++; $display("FAIL ovf_fill got l=%0d o=%b d=%0d exp 8/1/1", level, overflow, drops); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
                errs++; $display("FAIL drain_order got v=%b d=%0d exp 1/%0d", out_valid, out_data, i); end
            step(0, 0, 0, 1, 0);
        end
        checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin
            errs++; $display("FAIL drain_empty got v=%b l=%0d exp 0/0", out_valid, level); end
        step(0, 0, 0, 0, 1);
        checks++; if (overflow !== 1'b0 || drops !== 8'd0) begin
            errs++; $display("FAIL clear got o=%b d=%0d exp 0/0", overflow, drops); end
    endtask

    task automatic test_full_pop;
        for (int i = 0; i < 8; i++) step(2'b01, win_adr(), 32'h10 + 32'(i), 0, 0);
        step(2'b01, 32'h88, 32'hA5, 1, 0);
        checks++; if (level !== 4'd8 || drops !== 8'd0 || overflow !== 1'b0) begin
            errs++; $display("FAIL full_pop got l=%0d d=%0d o=%b exp 8/0/0", level, drops, overflow); end
        for (int r = 0; r < 4; r++) begin
            if (r > 0) for (int i = 0; i < 8; i++) step(2'($urandom_range(1, 3)), win_adr(), $urandom, 0, 0);
            while (q.size() != 0) begin
                checks++; if (out_valid !== 1'b1 || out_data !== q[0].d || out_adr !== q[0].a || out_kind !== q[0].k) begin
                    errs++; $display("FAIL wrap_drain r=%0d got d=%h a=%h exp d=%h a=%h", r, out_data, out_adr, q[0].d, q[0].a); end
                step(0, 0, 0, 1, 0);
            end
            if (r == 0) begin
                checks++; if (level !== 4'd0) begin errs++; $display("FAIL a5_last got l=%0d exp 0", level); end
            end
        end
    endtask

    task automatic test_streaming;
        logic [31:0] d;
        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            step(2'b01, win_adr(), d, 1, 0);
            checks++; if (out_valid !== 1'b1 || out_data !== d || level !== 4'd1) begin
                errs++; $display("FAIL stream i=%0d got v=%b d=%h l=%0d exp 1/%h/1", i, out_valid, out_data, level, d); end
        end
        step(0, 0, 0, 1, 0);
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stream_end got v=%b exp 0", out_valid); end
    endtask

    task automatic test_saturate_clear;
        for (int i = 0; i < 308; i++) step(2'b01, win_adr(), 32'(i), 0, 0);
        checks++; if (drops !== 8'hFF || overflow !== 1'b1 || level !== 4'd8) begin
            errs++; $display("FAIL saturate got d=%0d o=%b l=%0d exp 255/1/8", drops, overflow, level); end
        step(0, 0, 0, 0, 1);
        checks++; if (drops !== 8'd0 || overflow !== 1'b0) begin
            errs++; $display("FAIL sat_clear got d=%0d o=%b exp 0/0", drops, overflow); end
        step(2'b01, 32'h90, 32'h77, 0, 0);
        step(2'b01, 32'h94, 32'h78, 0, 1);
        checks++; if (drops !== 8'd1 || overflow !== 1'b1) begin
            errs++; $display("FAIL clr_vs_drop got d=%0d o=%b exp 1/1", drops, overflow); end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        checks++; if (level !== 4'd5) begin errs++; $display("FAIL pre_reset got l=%0d exp 5", level); end
    endtask

    task automatic test_async_reset;
        #2 reset = 1;
        #1;
        checks++; if (level !== 4'd0 || out_valid !== 1'b0 || drops !== 8'd0 || overflow !== 1'b0) begin
            errs++; $display("FAIL async_reset got l=%0d v=%b d=%0d o=%b exp 0/0/0/0", level, out_valid, drops, overflow); end
        q.delete(); m_drops = 0; m_ovf = 0;
        @(negedge clk) reset = 0;
    endtask

    task automatic test_random;
        logic [31:0] a;
        for (int i = 0; i < 600; i++) begin
            a = ($urandom_range(0, 3) != 0) ? win_adr() : $urandom;
            step(2'($urandom_range(0, 3)), a, $urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 40) == 0));
            checks++; if (level !== 4'(q.size()) || out_valid !== (q.size() != 0)) begin
                errs++; $display("FAIL rnd_level i=%0d got l=%0d v=%b exp %0d", i, level, out_valid, q.size()); end
            if (q.size() != 0) begin
                checks++; if (out_kind !== q[0].k || out_adr !== q[0].a || out_data !== q[0].d) begin
                    errs++; $display("FAIL rnd_head i=%0d got %b/%h/%h exp %b/%h/%h", i, out_kind, out_adr, out_data, q[0].k, q[0].a, q[0].d); end
            end
            checks++; if (drops !== 8'(m_drops) || overflow !== m_ovf) begin
                errs++; $display("FAIL rnd_drops i=%0d got %0d/%b exp %0d/%b", i, drops, overflow, m_drops, m_ovf); end
        end
    endtask

    initial begin
        test_reset;
        test_first_store;
        test_filter;
        test_overflow_drain;
        test_full_pop;
        test_streaming;
        test_saturate_clear;
        test_async_reset;
        test_random;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
